// File: rtl/myca_seq_if.sv
// myca_seq_if: decoder/status-facing bundle of the myca_seq program-counter sequencer.
interface myca_seq_if #(parameter int AW = 4, parameter int SD = 4);
  logic                      en;
  logic                      x;
  logic [2:0]                opc;
  logic [AW-1:0]             dir;
  logic                      clr_err;
  logic [AW-1:0]             pc;
  logic [$clog2(SD+1)-1:0]   lvl;
  logic                      ovf;
  logic                      unf;
  modport master (output en, x, opc, dir, clr_err, input pc, lvl, ovf, unf);
  modport slave  (input en, x, opc, dir, clr_err, output pc, lvl, ovf, unf);
endinterface

// File: rtl/myca_seq.sv
// myca_seq: PC sequencer with branches, CALL/RET stack and sticky stack-error flags.
// Define MYCA_SEQ_LOOP_EN to add the LDL/DJNZ loop counter; otherwise opcodes 110/111 hold.
module myca_seq #(
  parameter int            AW        = 4,
  parameter int            SD        = 4,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic      ck,
  input  logic      rst_n,
  myca_seq_if.slave bus
);
  localparam int LW = $clog2(SD+1);
  localparam logic [LW-1:0] FULL = LW'(SD);
  logic [AW-1:0] pc_q, pc_d, inc;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          ovf_q, ovf_d, unf_q, unf_d, push;
  // Sized to the full index range of lvl so it never needs truncation; entries >= SD are never written.
  logic [AW-1:0] stk_q [2**LW];
`ifdef MYCA_SEQ_LOOP_EN
  logic [AW-1:0] lc_q, lc_d;
`endif
  always_comb begin
    inc   = pc_q + 1'b1;
    pc_d  = pc_q;
    lvl_d = lvl_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
`ifdef MYCA_SEQ_LOOP_EN
    lc_d  = lc_q;
`endif
    if (bus.en) begin
      if (bus.clr_err) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      case (bus.opc)
        3'd0: pc_d = inc;
        3'd1: pc_d = bus.x ? inc : bus.dir;
        3'd2: pc_d = bus.dir;
        3'd3: pc_d = bus.x ? bus.dir : inc;
        3'd4: begin
          push  = lvl_q != FULL;
          pc_d  = push ? bus.dir : inc;
          lvl_d = push ? lvl_q + 1'b1 : lvl_q;
          ovf_d = push ? ovf_d : 1'b1;
        end
        3'd5: begin
          pc_d  = (lvl_q != '0) ? stk_q[lvl_q - 1'b1] : inc;
          lvl_d = (lvl_q != '0) ? lvl_q - 1'b1 : lvl_q;
          unf_d = (lvl_q != '0) ? unf_d : 1'b1;
        end
`ifdef MYCA_SEQ_LOOP_EN
        3'd6: begin
          lc_d = bus.dir;
          pc_d = inc;
        end
        3'd7: begin
          lc_d = (lc_q != '0) ? lc_q - 1'b1 : lc_q;
          pc_d = (lc_q != '0 && lc_q != AW'(1)) ? bus.dir : inc;
        end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef MYCA_SEQ_LOOP_EN
      lc_q  <= '0;
`endif
    end else begin
      pc_q  <= pc_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef MYCA_SEQ_LOOP_EN
      lc_q  <= lc_d;
`endif
    end
  always_ff @(posedge ck)
    if (push) stk_q[lvl_q] <= inc;
  assign bus.pc  = pc_q;
  assign bus.lvl = lvl_q;
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
endmodule

// File: tb/tb_myca_seq.sv
// tb_myca_seq: table-driven check of myca_seq (AW=4, SD=2, RESET_VEC=E) with an expected-value queue.
module tb_myca_seq;
  logic ck = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 ck = ~ck;
  myca_seq_if #(.AW(4), .SD(2)) bus ();
  myca_seq #(.AW(4), .SD(2), .RESET_VEC(4'hE)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));
  typedef struct {
    string      name;
    logic       en, x, clr;
    logic [2:0] opc;
    logic [3:0] dir;
    logic [3:0] pc;
    logic [1:0] lvl;
    logic       ovf, unf;
  } vec_t;
  vec_t tv[$];
  vec_t sb[$];
  function automatic vec_t v(string name, logic en, logic x, logic clr, logic [2:0] opc,
                             logic [3:0] dir, logic [3:0] pc, logic [1:0] lvl, logic ovf, logic unf);
    vec_t r;
    r.name = name; r.en = en; r.x = x; r.clr = clr; r.opc = opc; r.dir = dir;
    r.pc = pc; r.lvl = lvl; r.ovf = ovf; r.unf = unf;
    return r;
  endfunction
  task automatic check(string name, logic [3:0] pc, logic [1:0] lvl, logic ovf, logic unf);
    n_chk++;
    if ({bus.pc, bus.lvl, bus.ovf, bus.unf} !== {pc, lvl, ovf, unf}) begin
      n_fail++;
      $display("FAIL %s: got pc=%h lvl=%0d ovf=%b unf=%b, expected pc=%h lvl=%0d ovf=%b unf=%b",
               name, bus.pc, bus.lvl, bus.ovf, bus.unf, pc, lvl, ovf, unf);
    end
  endtask
  task automatic apply(vec_t t);
    vec_t e;
    bus.en = t.en; bus.x = t.x; bus.clr_err = t.clr; bus.opc = t.opc; bus.dir = t.dir;
    sb.push_back(t);
    @(posedge ck);
    #1;
    e = sb.pop_front();
    check(e.name, e.pc, e.lvl, e.ovf, e.unf);
  endtask
  initial begin
    bus.en = 1'b0; bus.x = 1'b0; bus.clr_err = 1'b0; bus.opc = 3'd0; bus.dir = 4'h0;
    repeat (2) @(posedge ck);
    #1;
    check("reset", 4'hE, 2'd0, 1'b0, 1'b0);
    @(negedge ck) rst_n = 1'b1;
    tv.push_back(v("inc_f",    1, 0, 0, 3'd0, 4'h0, 4'hF, 2'd0, 0, 0));
    tv.push_back(v("inc_wrap", 1, 0, 0, 3'd0, 4'h0, 4'h0, 2'd0, 0, 0));
    tv.push_back(v("inc_1",    1, 0, 0, 3'd0, 4'h0, 4'h1, 2'd0, 0, 0));
    foreach (tv[i]) apply(tv[i]);
    tv.delete();
    #2 rst_n = 1'b0;
    #1 check("async_reset", 4'hE, 2'd0, 1'b0, 1'b0);
    @(negedge ck) rst_n = 1'b1;
    tv.push_back(v("jmp3",       1, 0, 0, 3'd2, 4'h3, 4'h3, 2'd0, 0, 0));
    tv.push_back(v("jnx_x1",     1, 1, 0, 3'd1, 4'h9, 4'h4, 2'd0, 0, 0));
    tv.push_back(v("jmp3b",      1, 0, 0, 3'd2, 4'h3, 4'h3, 2'd0, 0, 0));
    tv.push_back(v("jnx_x0",     1, 0, 0, 3'd1, 4'h9, 4'h9, 2'd0, 0, 0));
    tv.push_back(v("jx_x1",      1, 1, 0, 3'd3, 4'h2, 4'h2, 2'd0, 0, 0));
    tv.push_back(v("jx_x0",      1, 0, 0, 3'd3, 4'h9, 4'h3, 2'd0, 0, 0));
    tv.push_back(v("jmp7",       1, 0, 0, 3'd2, 4'h7, 4'h7, 2'd0, 0, 0));
    tv.push_back(v("hold_en0",   0, 0, 0, 3'd2, 4'h9, 4'h7, 2'd0, 0, 0));
    tv.push_back(v("jmp1",       1, 0, 0, 3'd2, 4'h1, 4'h1, 2'd0, 0, 0));
    tv.push_back(v("call8",      1, 0, 0, 3'd4, 4'h8, 4'h8, 2'd1, 0, 0));
    tv.push_back(v("callC",      1, 0, 0, 3'd4, 4'hC, 4'hC, 2'd2, 0, 0));
    tv.push_back(v("ret_9",      1, 0, 0, 3'd5, 4'h0, 4'h9, 2'd1, 0, 0));
    tv.push_back(v("ret_2",      1, 0, 0, 3'd5, 4'h0, 4'h2, 2'd0, 0, 0));
    tv.push_back(v("jmp0",       1, 0, 0, 3'd2, 4'h0, 4'h0, 2'd0, 0, 0));
    tv.push_back(v("call5",      1, 0, 0, 3'd4, 4'h5, 4'h5, 2'd1, 0, 0));
    tv.push_back(v("call6",      1, 0, 0, 3'd4, 4'h6, 4'h6, 2'd2, 0, 0));
    tv.push_back(v("call_ovf",   1, 0, 0, 3'd4, 4'h7, 4'h7, 2'd2, 1, 0));
    tv.push_back(v("clr_en0",    0, 0, 1, 3'd0, 4'h0, 4'h7, 2'd2, 1, 0));
    tv.push_back(v("ret_6",      1, 0, 0, 3'd5, 4'h0, 4'h6, 2'd1, 1, 0));
    tv.push_back(v("ret_1",      1, 0, 0, 3'd5, 4'h0, 4'h1, 2'd0, 1, 0));
    tv.push_back(v("ret_unf",    1, 0, 0, 3'd5, 4'h0, 4'h2, 2'd0, 1, 1));
    tv.push_back(v("clr",        1, 0, 1, 3'd0, 4'h0, 4'h3, 2'd0, 0, 0));
    tv.push_back(v("call8b",     1, 0, 0, 3'd4, 4'h8, 4'h8, 2'd1, 0, 0));
    tv.push_back(v("call9",      1, 0, 0, 3'd4, 4'h9, 4'h9, 2'd2, 0, 0));
    tv.push_back(v("call_ovf2",  1, 0, 0, 3'd4, 4'hA, 4'hA, 2'd2, 1, 0));
    tv.push_back(v("ret_9b",     1, 0, 0, 3'd5, 4'h0, 4'h9, 2'd1, 1, 0));
    tv.push_back(v("ret_4",      1, 0, 0, 3'd5, 4'h0, 4'h4, 2'd0, 1, 0));
    tv.push_back(v("clr_vs_unf", 1, 0, 1, 3'd5, 4'h0, 4'h5, 2'd0, 0, 1));
    tv.push_back(v("clr2",       1, 0, 1, 3'd0, 4'h0, 4'h6, 2'd0, 0, 0));
    tv.push_back(v("jmp0b",      1, 0, 0, 3'd2, 4'h0, 4'h0, 2'd0, 0, 0));
`ifdef MYCA_SEQ_LOOP_EN
    tv.push_back(v("ldl3",       1, 0, 0, 3'd6, 4'h3, 4'h1, 2'd0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      tv.push_back(v("body",     1, 0, 0, 3'd0, 4'h0, 4'h2, 2'd0, 0, 0));
      tv.push_back(v("djnz",     1, 0, 0, 3'd7, 4'h1, (k == 2) ? 4'h3 : 4'h1, 2'd0, 0, 0));
    end
    tv.push_back(v("djnz_lc0",   1, 0, 0, 3'd7, 4'h1, 4'h4, 2'd0, 0, 0));
    tv.push_back(v("inc_after",  1, 0, 0, 3'd0, 4'h0, 4'h5, 2'd0, 0, 0));
`else
    tv.push_back(v("jmp2",       1, 0, 0, 3'd2, 4'h2, 4'h2, 2'd0, 0, 0));
    tv.push_back(v("hold111",    1, 0, 0, 3'd7, 4'h1, 4'h2, 2'd0, 0, 0));
    tv.push_back(v("hold110",    1, 0, 0, 3'd6, 4'h5, 4'h2, 2'd0, 0, 0));
    tv.push_back(v("inc_after",  1, 0, 0, 3'd0, 4'h0, 4'h3, 2'd0, 0, 0));
`endif
    foreach (tv[i]) apply(tv[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
